// File: rtl/hp_mem_slave.sv
// ----------------------------------------------------------------------------
// hp_mem_slave
//
// Burst-capable AXI4 responder for a 128-bit HP port, backed by a local
// block-RAM window. It stands in for the memory side of the host so that
// kernel-level simulation and board loopback can issue real HP bursts.
// One transaction is served at a time. Beats inside a burst move at one
// per cycle.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   hp_aw*  (addr/len/size/burst/valid/ready)   write request channel
//   hp_w*   (data/strb/last/valid/ready)        write data channel
//   hp_b*   (resp/valid/ready)                  write response channel
//   hp_ar*  (addr/len/size/burst/valid/ready)   read request channel
//   hp_r*   (data/resp/last/valid/ready)        read data channel
//
// Addressing: word index = addr[MEM_ADDR_WIDTH+B-1:B] with B = log2(bytes per
// beat). The upper address bits are ignored, so the window aliases across the
// whole address space. The sub-word byte offset is ignored.
//
// Error handling: a request with size != B, or with a WRAP or reserved burst
// type, completes its full handshake sequence but does not touch memory.
// Such a write answers SLVERR, and such a read returns zero data with SLVERR
// on every beat. A write whose wlast does not line up with awlen also answers
// SLVERR. Beats written before the mismatch are kept.
// ----------------------------------------------------------------------------
module hp_mem_slave #(
  parameter int HP_ADDR_WIDTH  = 48,
  parameter int HP_DATA_WIDTH  = 128,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  // write request
  input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]                 hp_awlen,
  input  logic [2:0]                 hp_awsize,
  input  logic [1:0]                 hp_awburst,
  input  logic                       hp_awvalid,
  output logic                       hp_awready,
  // write data
  input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                       hp_wlast,
  input  logic                       hp_wvalid,
  output logic                       hp_wready,
  // write response
  output logic [1:0]                 hp_bresp,
  output logic                       hp_bvalid,
  input  logic                       hp_bready,
  // read request
  input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]                 hp_arlen,
  input  logic [2:0]                 hp_arsize,
  input  logic [1:0]                 hp_arburst,
  input  logic                       hp_arvalid,
  output logic                       hp_arready,
  // read data
  output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]                 hp_rresp,
  output logic                       hp_rlast,
  output logic                       hp_rvalid,
  input  logic                       hp_rready
);

  localparam int STRB_W = HP_DATA_WIDTH / 8;
  localparam int B      = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_RFETCH,
    S_READ
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Held low through reset and for the first cycle after it, so the request
  // channels only open once reset has fully released.
  logic                      r_active;
  logic [MEM_ADDR_WIDTH-1:0] r_idx;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic                      r_fixed;
  logic                      r_err;
  logic [HP_DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [HP_DATA_WIDTH-1:0]  r_rd_q;

  logic                      w_aw_hs;
  logic                      w_ar_hs;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic                      w_r_hs;
  logic                      w_last_beat;
  logic                      w_aw_bad;
  logic                      w_ar_bad;
  logic                      w_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] w_idx_next;
  logic [MEM_ADDR_WIDTH-1:0] w_aw_idx;
  logic [MEM_ADDR_WIDTH-1:0] w_ar_idx;

  assign w_aw_hs     = hp_awvalid & hp_awready;
  assign w_ar_hs     = hp_arvalid & hp_arready;
  assign w_w_hs      = hp_wvalid  & hp_wready;
  assign w_b_hs      = hp_bvalid  & hp_bready;
  assign w_r_hs      = hp_rvalid  & hp_rready;
  assign w_last_beat = (r_beat == r_len);

  assign w_aw_idx = hp_awaddr[MEM_ADDR_WIDTH+B-1:B];
  assign w_ar_idx = hp_araddr[MEM_ADDR_WIDTH+B-1:B];

  // Only full-width INCR and FIXED bursts are supported.
  assign w_aw_bad = (hp_awsize != 3'(B)) | hp_awburst[1];
  assign w_ar_bad = (hp_arsize != 3'(B)) | hp_arburst[1];

  // INCR wraps modulo the window depth through the natural index overflow.
  assign w_idx_next = r_fixed ? r_idx : r_idx + MEM_ADDR_WIDTH'(1);

  // The RAM has one cycle of read latency. RFETCH primes the first word. Each
  // accepted beat except the last then prefetches the following word, so
  // r_rd_q already holds the next beat when the handshake completes.
  assign w_rd_en = (r_state == S_RFETCH) | (w_r_hs & ~w_last_beat);

  // Address bits outside the window and the sub-word offset are not used.
  logic w_unused;
  assign w_unused = ^{hp_awaddr[HP_ADDR_WIDTH-1:MEM_ADDR_WIDTH+B], hp_awaddr[B-1:0],
                      hp_araddr[HP_ADDR_WIDTH-1:MEM_ADDR_WIDTH+B], hp_araddr[B-1:0]};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order in which blocks are evaluated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case
  // statement, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        // A write beats a read when both requests arrive together, because
        // arready is suppressed whenever awvalid is high.
        if (w_aw_hs) begin
          w_next_state = S_WRITE;
        end else if (w_ar_hs) begin
          w_next_state = S_RFETCH;
        end
      end
      S_WRITE: begin
        // The burst length comes from awlen. wlast is only checked.
        if (w_w_hs && w_last_beat) begin
          w_next_state = S_WRESP;
        end
      end
      S_WRESP: begin
        if (w_b_hs) begin
          w_next_state = S_IDLE;
        end
      end
      S_RFETCH: begin
        w_next_state = S_READ;
      end
      S_READ: begin
        if (w_r_hs && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    hp_awready = 1'b0;
    hp_arready = 1'b0;
    hp_wready  = 1'b0;
    hp_bvalid  = 1'b0;
    hp_bresp   = RESP_OKAY;
    hp_rvalid  = 1'b0;
    hp_rlast   = 1'b0;
    hp_rresp   = RESP_OKAY;
    hp_rdata   = '0;
    unique case (r_state)
      S_IDLE: begin
        hp_awready = r_active;
        hp_arready = r_active & ~hp_awvalid;
      end
      S_WRITE: begin
        hp_wready = 1'b1;
      end
      S_WRESP: begin
        hp_bvalid = 1'b1;
        hp_bresp  = r_err ? RESP_SLVERR : RESP_OKAY;
      end
      S_READ: begin
        // Every payload field comes from registers that change only on a
        // handshake, so the payload stays stable while the master stalls.
        hp_rvalid = 1'b1;
        hp_rlast  = w_last_beat;
        hp_rresp  = r_err ? RESP_SLVERR : RESP_OKAY;
        hp_rdata  = r_err ? '0 : r_rd_q;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction context: start index, length, beat count, burst type, error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_fixed  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_idx   <= w_aw_idx;
            r_len   <= hp_awlen;
            r_fixed <= (hp_awburst == 2'b00);
            r_err   <= w_aw_bad;
            r_beat  <= '0;
          end else if (w_ar_hs) begin
            r_idx   <= w_ar_idx;
            r_len   <= hp_arlen;
            r_fixed <= (hp_arburst == 2'b00);
            r_err   <= w_ar_bad;
            r_beat  <= '0;
          end
        end
        S_WRITE: begin
          if (w_w_hs) begin
            r_idx <= w_idx_next;
            if (w_last_beat) begin
              r_err <= r_err | ~hp_wlast;
            end else begin
              r_err  <= r_err | hp_wlast;
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        S_RFETCH: begin
          r_idx <= w_idx_next;
        end
        S_READ: begin
          if (w_r_hs) begin
            r_beat <= r_beat + 8'd1;
            if (!w_last_beat) begin
              r_idx <= w_idx_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Block RAM: byte-strobed write port, registered read port
  // --------------------------------------------------------------------------
  // NOTE: the array and its read register have no reset. Memory contents
  // survive reset, and a reset term would stop the array from mapping onto
  // block RAM. The read register never reaches hp_rdata outside READ.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE && w_w_hs && !r_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (hp_wstrb[i]) begin
          r_mem[r_idx][i*8 +: 8] <= hp_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rd_q <= r_mem[r_idx];
    end
  end

endmodule

// File: tb/tb_hp_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_hp_mem_slave
//
// Directed and randomized bench for hp_mem_slave. A word-array model of the
// 16 KiB window holds the expected contents. Each write updates the model
// from the burst rules: the word index is (addr / 16) mod 1024, INCR steps
// that index and FIXED holds it, strobes select bytes, and an error request
// writes nothing. Each read beat is compared against the model.
// ----------------------------------------------------------------------------
module tb_hp_mem_slave;

  localparam int DEPTH = 1024;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [47:0]   hp_awaddr  = '0;
  logic [7:0]    hp_awlen   = '0;
  logic [2:0]    hp_awsize  = '0;
  logic [1:0]    hp_awburst = '0;
  logic          hp_awvalid = 1'b0;
  logic          hp_awready;
  logic [127:0]  hp_wdata   = '0;
  logic [15:0]   hp_wstrb   = '0;
  logic          hp_wlast   = 1'b0;
  logic          hp_wvalid  = 1'b0;
  logic          hp_wready;
  logic [1:0]    hp_bresp;
  logic          hp_bvalid;
  logic          hp_bready  = 1'b0;
  logic [47:0]   hp_araddr  = '0;
  logic [7:0]    hp_arlen   = '0;
  logic [2:0]    hp_arsize  = '0;
  logic [1:0]    hp_arburst = '0;
  logic          hp_arvalid = 1'b0;
  logic          hp_arready;
  logic [127:0]  hp_rdata;
  logic [1:0]    hp_rresp;
  logic          hp_rlast;
  logic          hp_rvalid;
  logic          hp_rready  = 1'b0;

  always #5 clk = ~clk;

  hp_mem_slave #(
    .HP_ADDR_WIDTH (48),
    .HP_DATA_WIDTH (128),
    .MEM_ADDR_WIDTH(10)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .hp_awaddr (hp_awaddr),
    .hp_awlen  (hp_awlen),
    .hp_awsize (hp_awsize),
    .hp_awburst(hp_awburst),
    .hp_awvalid(hp_awvalid),
    .hp_awready(hp_awready),
    .hp_wdata  (hp_wdata),
    .hp_wstrb  (hp_wstrb),
    .hp_wlast  (hp_wlast),
    .hp_wvalid (hp_wvalid),
    .hp_wready (hp_wready),
    .hp_bresp  (hp_bresp),
    .hp_bvalid (hp_bvalid),
    .hp_bready (hp_bready),
    .hp_araddr (hp_araddr),
    .hp_arlen  (hp_arlen),
    .hp_arsize (hp_arsize),
    .hp_arburst(hp_arburst),
    .hp_arvalid(hp_arvalid),
    .hp_arready(hp_arready),
    .hp_rdata  (hp_rdata),
    .hp_rresp  (hp_rresp),
    .hp_rlast  (hp_rlast),
    .hp_rvalid (hp_rvalid),
    .hp_rready (hp_rready)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] m_mem [DEPTH];
  logic [127:0] wd    [256];
  logic [15:0]  ws    [256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [47:0] a);
    return int'((a >> 4) % 48'(DEPTH));
  endfunction

  function automatic logic bad_req(input logic [2:0] sz, input logic [1:0] bu);
    return (sz != 3'd4) || (bu > 2'd1);
  endfunction

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction. Bursts use wd[]/ws[]. early >= 0 raises wlast on
  // that beat as well as on the last one, which makes the transaction an
  // error. The model is updated only for clean writes.
  task automatic do_write(input string tag, input logic [47:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int early);
    int   n;
    int   idx;
    logic err;
    logic [1:0] resp;
    hp_awaddr  = addr;
    hp_awlen   = 8'(len);
    hp_awsize  = size;
    hp_awburst = burst;
    hp_awvalid = 1'b1;
    #1;
    n = 0;
    while (!hp_awready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_awready"}, 128'(hp_awready), 1);
    tick();
    hp_awvalid = 1'b0;
    check({tag, "_wready_t1"}, 128'(hp_wready), 1);
    check({tag, "_awready_busy"}, 128'(hp_awready), 0);
    check({tag, "_arready_busy"}, 128'(hp_arready), 0);
    err = bad_req(size, burst);
    idx = widx(addr);
    for (int b = 0; b <= len; b++) begin
      hp_wdata  = wd[b];
      hp_wstrb  = ws[b];
      hp_wlast  = (b == len) || (b == early);
      hp_wvalid = 1'b1;
      #1;
      check({tag, "_wready"}, 128'(hp_wready), 1);
      if (!err && early < 0) begin
        for (int i = 0; i < 16; i++) begin
          if (ws[b][i]) m_mem[idx][i*8 +: 8] = wd[b][i*8 +: 8];
        end
      end
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
      tick();
    end
    hp_wvalid = 1'b0;
    hp_wlast  = 1'b0;
    check({tag, "_bvalid_t1"}, 128'(hp_bvalid), 1);
    hp_bready = 1'b1;
    #1;
    resp = hp_bresp;
    check({tag, "_bresp"}, 128'(resp), (err || early >= 0) ? 128'd2 : 128'd0);
    tick();
    hp_bready = 1'b0;
    #1;
    check({tag, "_bvalid_drop"}, 128'(hp_bvalid), 0);
    check({tag, "_awready_next"}, 128'(hp_awready), 1);
  endtask

  // Full read transaction. mode 0: rready held high, 1: pattern 1,0,0,...,
  // 2: random rready. Each beat is compared against the model, and payload
  // stability is checked on every stalled cycle.
  task automatic do_read(input string tag, input logic [47:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    int   n;
    int   idx;
    int   beat;
    int   cyc;
    logic err;
    logic held;
    logic rr;
    logic [127:0] s_data;
    logic [1:0]   s_resp;
    logic         s_last;
    hp_araddr  = addr;
    hp_arlen   = 8'(len);
    hp_arsize  = size;
    hp_arburst = burst;
    hp_arvalid = 1'b1;
    #1;
    n = 0;
    while (!hp_arready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_arready"}, 128'(hp_arready), 1);
    tick();
    hp_arvalid = 1'b0;
    check({tag, "_rvalid_t1"}, 128'(hp_rvalid), 0);
    check({tag, "_arready_busy"}, 128'(hp_arready), 0);
    tick();
    err  = bad_req(size, burst);
    idx  = widx(addr);
    beat = 0;
    cyc  = 0;
    held = 1'b0;
    s_data = '0;
    s_resp = '0;
    s_last = 1'b0;
    while (beat <= len && cyc < 400) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      hp_rready = rr;
      #1;
      check({tag, "_rvalid"}, 128'(hp_rvalid), 1);
      if (held) begin
        check({tag, "_hold_data"}, hp_rdata, s_data);
        check({tag, "_hold_resp"}, 128'(hp_rresp), 128'(s_resp));
        check({tag, "_hold_last"}, 128'(hp_rlast), 128'(s_last));
      end
      if (rr) begin
        check({tag, "_rdata"}, hp_rdata, err ? 128'd0 : m_mem[idx]);
        check({tag, "_rresp"}, 128'(hp_rresp), err ? 128'd2 : 128'd0);
        check({tag, "_rlast"}, 128'(hp_rlast), 128'(beat == len));
        beat++;
        if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        held = 1'b0;
      end else begin
        s_data = hp_rdata;
        s_resp = hp_rresp;
        s_last = hp_rlast;
        held   = 1'b1;
      end
      tick();
      cyc++;
    end
    check({tag, "_beats"}, 128'(beat), 128'(len + 1));
    hp_rready = 1'b0;
    #1;
    check({tag, "_rvalid_drop"}, 128'(hp_rvalid), 0);
    check({tag, "_arready_next"}, 128'(hp_arready), 1);
  endtask

  task automatic rand_data(input int len);
    for (int b = 0; b <= len; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom};
      ws[b] = 16'hFFFF;
    end
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    logic [63:0]  r64;
    logic [47:0]  addr;
    int           len;
    logic [1:0]   burst;
    logic [2:0]   size;

    // ---------------- reset with both requests asserted ----------------
    #1;
    rstn       = 1'b0;
    hp_awvalid = 1'b1;
    hp_arvalid = 1'b1;
    hp_awsize  = 3'd4;
    hp_arsize  = 3'd4;
    hp_awburst = 2'b01;
    hp_arburst = 2'b01;
    tick();
    tick();
    tick();
    check("rst_awready", 128'(hp_awready), 0);
    check("rst_arready", 128'(hp_arready), 0);
    check("rst_wready",  128'(hp_wready), 0);
    check("rst_bvalid",  128'(hp_bvalid), 0);
    check("rst_bresp",   128'(hp_bresp), 0);
    check("rst_rvalid",  128'(hp_rvalid), 0);
    check("rst_rlast",   128'(hp_rlast), 0);
    check("rst_rresp",   128'(hp_rresp), 0);
    check("rst_rdata",   hp_rdata, 0);
    rstn       = 1'b1;
    hp_awvalid = 1'b0;
    hp_arvalid = 1'b0;
    #1;
    check("rel_awready_same", 128'(hp_awready), 0);
    tick();
    check("rel_awready_next", 128'(hp_awready), 1);
    check("rel_arready_next", 128'(hp_arready), 1);

    // ---------------- fill the whole window so every read is known ----------------
    for (int k = 0; k < 4; k++) begin
      rand_data(255);
      do_write("fill", 48'(k * 4096), 255, 3'd4, 2'b01, -1);
    end

    // ---------------- INCR write/read of A0..A3 at 0x1000 ----------------
    for (int b = 0; b < 4; b++) begin
      wd[b] = {120'h00112233445566778899AABBCCDDEE, 8'(8'hA0 + b)};
      ws[b] = 16'hFFFF;
    end
    do_write("incr_wr", 48'h1000, 3, 3'd4, 2'b01, -1);
    do_read("incr_rd", 48'h1000, 3, 3'd4, 2'b01, 0);

    // ---------------- strobes with FIXED: Y[31:0] over X ----------------
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    wd[0] = x; ws[0] = 16'hFFFF;
    wd[1] = y; ws[1] = 16'h000F;
    do_write("fixed_wr", 48'h20, 1, 3'd4, 2'b00, -1);
    do_read("fixed_rd", 48'h20, 0, 3'd4, 2'b01, 0);

    // ---------------- rready backpressure on an 8-beat read ----------------
    do_read("bp_rd", 48'h2000, 7, 3'd4, 2'b01, 1);

    // ---------------- error cases ----------------
    rand_data(1);
    do_write("size_err_wr", 48'h3000, 1, 3'd3, 2'b01, -1);
    do_read("size_err_rd", 48'h3000, 1, 3'd4, 2'b01, 0);
    do_read("wrap_err_rd", 48'h1000, 2, 3'd4, 2'b10, 0);
    rand_data(1);
    do_write("wlast_err_wr", 48'h500, 1, 3'd4, 2'b01, 0);
    rand_data(1);
    do_write("wlast_fix_wr", 48'h500, 1, 3'd4, 2'b01, -1);
    do_read("wlast_fix_rd", 48'h500, 1, 3'd4, 2'b01, 0);

    // ---------------- simultaneous AW/AR: write first, then read ----------------
    rand_data(1);
    hp_araddr  = 48'h6000;
    hp_arlen   = 8'd1;
    hp_arsize  = 3'd4;
    hp_arburst = 2'b01;
    hp_arvalid = 1'b1;
    hp_awaddr  = 48'h6000;
    hp_awlen   = 8'd1;
    hp_awsize  = 3'd4;
    hp_awburst = 2'b01;
    hp_awvalid = 1'b1;
    #1;
    check("arb_awready", 128'(hp_awready), 1);
    check("arb_arready", 128'(hp_arready), 0);
    do_write("arb_wr", 48'h6000, 1, 3'd4, 2'b01, -1);
    do_read("arb_rd", 48'h6000, 1, 3'd4, 2'b01, 0);

    // ---------------- aliasing ----------------
    rand_data(0);
    do_write("alias_wr", 48'h4000, 0, 3'd4, 2'b01, -1);
    do_read("alias_rd", 48'h0, 0, 3'd4, 2'b01, 0);
    rand_data(1);
    do_write("alias_hi_wr", 48'hABC0_0000_0FF0, 1, 3'd4, 2'b01, -1);
    do_read("alias_hi_rd", 48'h3FF0, 1, 3'd4, 2'b01, 2);

    // ---------------- randomized transactions ----------------
    for (int t = 0; t < 30; t++) begin
      r64   = {$urandom, $urandom};
      addr  = r64[47:0];
      len   = $urandom_range(0, 15);
      burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wd[b] = {$urandom, $urandom, $urandom, $urandom};
          ws[b] = 16'($urandom);
        end
        do_write("rnd_wr", addr, len, size, burst, -1);
      end else begin
        do_read("rnd_rd", addr, len, size, burst, 2);
      end
    end

    // ---------------- reset in the middle of a read burst ----------------
    hp_araddr  = 48'h100;
    hp_arlen   = 8'd7;
    hp_arsize  = 3'd4;
    hp_arburst = 2'b01;
    hp_arvalid = 1'b1;
    #1;
    check("mid_arready", 128'(hp_arready), 1);
    tick();
    hp_arvalid = 1'b0;
    tick();
    tick();
    check("mid_rvalid_before", 128'(hp_rvalid), 1);
    rstn = 1'b0;
    #1;
    check("mid_rvalid_rst", 128'(hp_rvalid), 0);
    tick();
    rstn = 1'b1;
    hp_rready = 1'b1;
    tick();
    tick();
    tick();
    check("mid_rvalid_after", 128'(hp_rvalid), 0);
    check("mid_arready_after", 128'(hp_arready), 1);
    hp_rready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp_mem_slave.md
# hp_mem_slave

Burst-capable AXI4 responder for the 128-bit HP port, backing a local block-RAM window. It sits at the far end of the kernel's HP master interface and stands in for the NVMe driver's memory side. Kernel-level simulation and on-board loopback use it to accept HP write bursts and return HP read bursts. It serves one transaction at a time, with full-throughput beats inside a burst.

## Interface
- HP_ADDR_WIDTH, 48, byte address width (256 TiB space)
- HP_DATA_WIDTH, 128, data width; power of two, ≥32
- MEM_ADDR_WIDTH, 10, log2 of memory depth in data words (default 1024×16 B = 16 KiB)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- hp_awaddr  in  HP_ADDR_WIDTH  write start byte address
- hp_awlen  in  8  beats−1
- hp_awsize  in  3  log2 bytes per beat
- hp_awburst  in  2  burst type
- hp_awvalid / hp_awready  in / out  1  AW handshake
- hp_wdata  in  HP_DATA_WIDTH  write data
- hp_wstrb  in  HP_DATA_WIDTH/8  byte enables
- hp_wlast  in  1  last write beat
- hp_wvalid / hp_wready  in / out  1  W handshake
- hp_bresp  out  2  write response
- hp_bvalid / hp_bready  out / in  1  B handshake
- hp_araddr, hp_arlen, hp_arsize, hp_arburst  in  as AW  read request
- hp_arvalid / hp_arready  in / out  1  AR handshake
- hp_rdata  out  HP_DATA_WIDTH  read data
- hp_rresp  out  2  read response
- hp_rlast  out  1  last read beat
- hp_rvalid / hp_rready  out / in  1  R handshake

## Operation
- Word index = addr[MEM_ADDR_WIDTH+B−1:B], where B = log2(HP_DATA_WIDTH/8). Upper address bits are ignored, so the window aliases. addr[B−1:0] is ignored.
- FSM states: IDLE, WRITE, WRESP, RFETCH, READ.
- IDLE:
  - hp_awready=1.
  - hp_arready = !hp_awvalid, so write wins on simultaneous AW/AR.
  - AW handshake → latch addr/len/burst, compute err, go to WRITE.
  - AR handshake → latch the same fields, go to RFETCH.
- err is set when either condition holds:
  - size ≠ B
  - burst ∉ {00 FIXED, 01 INCR}; WRAP and reserved are errors.
- WRITE:
  - hp_wready=1.
  - Each beat writes strobed bytes to mem[idx] unless err is set.
  - INCR: idx+1 per beat, wrapping modulo depth. FIXED: idx held.
  - Beat counter runs 0..len. The burst ends on beat len regardless of hp_wlast.
  - hp_wlast mismatch sets err: wlast=1 before beat len, or wlast=0 on beat len. Writes already done are kept.
  - After the last beat, go to WRESP.
- WRESP: hp_bvalid=1, hp_bresp = err ? 2'b10 : 2'b00. Leave to IDLE on hp_bready.
- Reads:
  - Synchronous RAM with 1-cycle latency.
  - RFETCH issues the read of the first idx, then goes to READ.
  - READ drives hp_rvalid=1. On an R handshake the next idx is already fetched, giving one beat per cycle.
  - rready=0 holds rdata, rresp, and rlast stable.
  - hp_rlast=1 on beat len.
  - err → rdata=0 and rresp=2'b10 on every beat, still len+1 beats.
  - Handshake on the last beat → IDLE.
- Memory is never cleared by reset.

## Timing
- Reset: all outputs 0 (awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, rdata); FSM → IDLE. Reset mid-burst abandons the transaction; no B/R is issued afterwards.
- AW handshake at cycle T → hp_wready=1 from T+1.
- Last W beat at T → hp_bvalid=1 at T+1.
- AR handshake at T → first hp_rvalid at T+2.
- With rready held high, a burst of N beats occupies T+2..T+N+1.
- Back-to-back transactions: the next AW/AR is accepted in the cycle after the B or last-R handshake. awready and arready are 0 outside IDLE.
- Valid signals never drop without a handshake. Payloads are stable while valid=1 and ready=0.
- Read-after-write to the same address in consecutive transactions returns the new data.

## Test plan
- Reset then idle: rstn low for 3 cycles with AR/AW asserted → all outputs 0; after release, awready=1 next cycle.
- INCR write/read: write len=3, addr 0x1000, data 0x…A0..A3, full strb → bresp=00 at T+1 after last. Read back same → 4 beats A0..A3, rlast on 4th, rresp=00, first rvalid 2 cycles after AR.
- Strobe + FIXED:
  - Write FIXED len=1 to 0x20: beat0 strb=0xFFFF data X, beat1 strb=0x000F data Y.
  - Read → Y[31:0] merged over X[127:32].
- rready backpressure: 8-beat read with rready toggling 1,0,0,1… → beats in order, payload held during stalls, exactly 8 handshakes.
- Errors:
  - awsize=3 write → bresp=10 and memory unchanged.
  - arburst=10 read len=2 → 3 beats of rdata=0, rresp=10.
  - wlast early on beat 0 of len=1 → bresp=10.
- Arbitration and aliasing:
  - AW and AR asserted in the same cycle → write served first, read after B handshake.
  - Write at 0x4000 (depth 16 KiB) → readable at 0x0.
